instr_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction memory: owns the program counter and drives `instr_rAddr`.
- Captures the combinational `instr_code` returned the same cycle into a small prefetch FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles taken branch/jump redirects with a FIFO flush.

---
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, captures instr_code into a small prefetch FIFO
// and presents {pc, instr} to decode. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] instr_rAddr,
    input  logic [31:0] instr_code,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_trap,
`endif
    output logic [31:0] out_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: decode takes the head when out_valid & out_ready are both high
    // at a rising edge; out_valid never depends on out_ready.
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic          deq, enq;

    assign instr_rAddr = pc_q;
    assign out_valid   = (count_q != '0);
    assign out_pc      = mem_pc_q[rd_ptr_q];
    assign out_instr   = mem_instr_q[rd_ptr_q];

    assign deq = out_valid & out_ready;
    assign enq = fetch_en & ~redirect & ((count_q < DEPTH_C) | deq);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    assign misalign_trap = trap_q;
`endif

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d   = 1'b0;
`endif
        if (redirect) begin
            // Flush wins over any concurrent dequeue; the presented head is dropped.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                pc_d   = TRAP_PC;
                trap_d = 1'b1;
            end else begin
                pc_d = redirect_pc;
            end
`else
            pc_d = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pc_d     = pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (enq && !deq) begin
                count_d = count_q + 1'b1;
            end else if (deq && !enq) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q   <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q   <= trap_d;
`endif
            if (enq) begin
                mem_pc_q[wr_ptr_q]    <= pc_q;
                mem_instr_q[wr_ptr_q] <= instr_code;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps followed by random traffic, every cycle
// checked against a queue-based model of the fetch pipeline.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_rAddr, instr_code, out_instr, out_pc;
    logic        out_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .TRAP_PC(TRAP_PC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_en(fetch_en),
        .instr_rAddr(instr_rAddr),
        .instr_code(instr_code),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
`endif
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: word content is a scramble of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction
    assign instr_code = mem_word(instr_rAddr);

    int          tests_run = 0;
    int          failed = 0;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic        m_trap;
    logic        model_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        chk("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
        chk("instr_rAddr", instr_rAddr, m_pc);
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("out_pc", out_pc, head[63:32]);
            chk("out_instr", out_instr, head[31:0]);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
`endif
    endtask

    // One clock: drive inputs after the falling edge, check, advance the model, clock.
    task automatic cycle(input logic rn, input logic fe, input logic rdy,
                         input logic rdr, input logic [31:0] rpc);
        logic deq_m;
        logic room;
        reset_n     = rn;
        fetch_en    = fe;
        out_ready   = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
        if (model_ok) check_outputs();
        m_trap = 1'b0;
        if (!rn) begin
            m_pc = RESET_PC;
            m_q.delete();
            model_ok = 1'b1;
        end else if (rdr) begin
            m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc % 4 != 0) begin
                m_pc   = TRAP_PC;
                m_trap = 1'b1;
            end else begin
                m_pc = rpc;
            end
`else
            m_pc = rpc - (rpc % 4);
`endif
        end else begin
            deq_m = (m_q.size() != 0) && rdy;
            room  = (m_q.size() < DEPTH) || deq_m;
            if (deq_m) void'(m_q.pop_front());
            if (fe && room) begin
                m_q.push_back({m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset state: empty, head slot cleared.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_raddr", instr_rAddr, RESET_PC);

        // Streaming with out_ready high: 0, 4, 8, 12 on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_pc", out_pc, 32'(i * 4));
        end

        // Backpressure: FIFO saturates, pc holds at 8, head stays at 0.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("bp_head", out_pc, 32'd0);
        chk("bp_pc_hold", instr_rAddr, 32'd8);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("bp_drain1", out_pc, 32'd4);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("bp_drain2", out_pc, 32'd8);

        // Redirect while holding 8 and 12: one bubble, then target.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        chk("redir_bubble", {31'b0, out_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("redir_target", out_pc, 32'h40);

        // Redirect concurrent with dequeue while full: flush wins.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("flush_bubble", {31'b0, out_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("flush_target", out_pc, 32'h200);

        // PC wrap.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("wrap0", out_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("wrap1", out_pc, 32'h0000_0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("wrap2", out_pc, 32'h0000_0004);

        // Misaligned redirect.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap_pulse", {31'b0, misalign_trap}, 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("trap_clear", {31'b0, misalign_trap}, 32'd0);
        chk("trap_pc", out_pc, TRAP_PC);
`else
        cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("align_pc", out_pc, 32'h40);
`endif

        // fetch_en low: pc holds while the FIFO drains.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("fe0_empty", {31'b0, out_valid}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            cycle(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 11) == 0),
                  rpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
